solve_play_ctrl: RTL and testbench

Sequencer between the front-panel buttons, the puzzle solver and the 7-segment display driver. It debounces the five buttons, starts the solver with a start/done handshake, and guards the search with a timeout. Once a solution is returned, it latches the solution and steps a move index through it manually or, optionally, automatically. It produces the step index, current move code and status that the display driver renders.

---
 rtl/solve_play_pkg.sv | 33 +++
 rtl/solve_play_ctrl_debounce.sv | 39 +++
 rtl/solve_play_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_solve_play_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/solve_play_pkg.sv
// solve_play_pkg: shared types and constants for the solve/play sequencer.
// States, button indices, move codes and a move-select helper.
package solve_play_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SOLVE = 2'd1,
        SHOW  = 2'd2,
        FAIL  = 2'd3
    } state_t;

    localparam int BTN_NEXT  = 4;
    localparam int BTN_PREV  = 3;
    localparam int BTN_START = 2;
    localparam int BTN_AUTO  = 1;
    localparam int BTN_RST   = 0;

    localparam logic [1:0] MV_UP    = 2'd0;
    localparam logic [1:0] MV_DOWN  = 2'd1;
    localparam logic [1:0] MV_LEFT  = 2'd2;
    localparam logic [1:0] MV_RIGHT = 2'd3;

    // Two-bit move k sits at bits [2k+1:2k] of the packed order.
    function automatic logic [1:0] move_at(
        input logic [17:0] ord,
        input logic [4:0]  idx
    );
        logic [17:0] sh;
        sh = ord >> {idx, 1'b0};
        return sh[1:0];
    endfunction

endpackage

// File: rtl/solve_play_ctrl_debounce.sv
// btn_debounce: tick-sampled two-sample debouncer for a button vector.
// Level flips after two equal samples; press is a one-clock rising pulse.
module btn_debounce #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic [W-1:0] raw,
    output logic [W-1:0] level,
    output logic [W-1:0] press
);

    logic [W-1:0] s0;
    logic [W-1:0] s1;

    // Two-deep sample history, shifted once per tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0 <= '0;
            s1 <= '0;
        end else if (tick) begin
            s0 <= raw;
            s1 <= s0;
        end
    end

    // Level follows two agreeing samples; pulse on its rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= '0;
            press <= '0;
        end else begin
            level <= (s0 & s1) | (level & (s0 | s1));
            press <= s0 & s1 & ~level;
        end
    end

endmodule

// File: rtl/solve_play_ctrl.sv
// solve_play_ctrl: buttons -> solver handshake -> stepped move display.
// Optional AUTOPLAY_EN macro builds the automatic stepping feature.
module solve_play_ctrl
    import solve_play_pkg::*;
#(
    parameter int TICK_W        = 12,
    parameter int MAX_MOVES     = 9,
    parameter int TIMEOUT_TICKS = 1000,
    parameter int AUTO_TICKS    = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  btn,
    output logic        slv_start,
    input  logic        slv_done,
    input  logic        slv_ok,
    input  logic [4:0]  slv_cnt,
    input  logic [17:0] slv_ord,
    output logic        comp,
    output logic [4:0]  step,
    output logic [1:0]  move,
    output logic [1:0]  st,
    output logic        auto_on
);

    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [4:0] CAP = 5'(MAX_MOVES);

    logic [TICK_W-1:0] presc;
    logic              tick;
    logic [4:0]        lvl;
    logic [4:0]        prs;
    state_t            state;
    state_t            nxt;
    logic [4:0]        cnt;
    logic [4:0]        nxt_cnt;
    logic [4:0]        nxt_step;
    logic [17:0]       ord;
    logic [17:0]       nxt_ord;
    logic [1:0]        nxt_move;
    logic [TO_W-1:0]   tcnt;
    logic [TO_W-1:0]   nxt_tcnt;
    logic              nxt_start;
    logic              auto_step;
    logic [4:0]        step_inc;
    logic              unused_lvl;

    assign tick       = &presc;
    assign st         = state;
    assign step_inc   = step + 5'd1;
    assign unused_lvl = ^lvl;

    // Free-running prescaler shared by debounce, timeout and autoplay.
    always_ff @(posedge clk) begin
        if (!rst_n) presc <= '0;
        else        presc <= presc + 1'b1;
    end

    btn_debounce #(.W(5)) u_db (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .raw   (btn),
        .level (lvl),
        .press (prs)
    );

    // Next state and datapath: restart, then done, timeout, start.
    always_comb begin
        nxt       = state;
        nxt_step  = step;
        nxt_ord   = ord;
        nxt_cnt   = cnt;
        nxt_start = 1'b0;
        nxt_tcnt  = '0;
        if (state == SOLVE)
            nxt_tcnt = tick ? tcnt + 1'b1 : tcnt;
        if (prs[BTN_RST]) begin
            nxt      = IDLE;
            nxt_step = '0;
            nxt_ord  = '0;
            nxt_cnt  = '0;
        end else begin
            case (state)
                IDLE, FAIL: begin
                    if (prs[BTN_START]) begin
                        nxt       = SOLVE;
                        nxt_start = 1'b1;
                    end
                end
                SOLVE: begin
                    if (slv_done) begin
                        if (slv_ok) begin
                            nxt      = SHOW;
                            nxt_ord  = slv_ord;
                            nxt_cnt  = (slv_cnt > CAP) ? CAP : slv_cnt;
                            nxt_step = '0;
                        end else begin
                            nxt = FAIL;
                        end
                    end else if (tcnt == TO_W'(TIMEOUT_TICKS)) begin
                        nxt = FAIL;
                    end
                end
                SHOW: begin
                    if (prs[BTN_NEXT]) begin
                        if (step_inc < cnt) nxt_step = step_inc;
                    end else if (prs[BTN_PREV]) begin
                        if (step != '0) nxt_step = step - 5'd1;
                    end else if (auto_step) begin
                        if (step_inc < cnt) nxt_step = step_inc;
                    end
                end
                default: ;
            endcase
        end
        nxt_move = (nxt_cnt == '0) ? MV_UP : move_at(nxt_ord, nxt_step);
    end

    // Registered outputs: step and move always change together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= '0;
            move      <= MV_UP;
            ord       <= '0;
            cnt       <= '0;
            comp      <= 1'b0;
            slv_start <= 1'b0;
            tcnt      <= '0;
        end else begin
            state     <= nxt;
            step      <= nxt_step;
            move      <= nxt_move;
            ord       <= nxt_ord;
            cnt       <= nxt_cnt;
            comp      <= (nxt == SHOW);
            slv_start <= nxt_start;
            tcnt      <= nxt_tcnt;
        end
    end

`ifdef AUTOPLAY_EN
    localparam int AW = $clog2(AUTO_TICKS + 1);

    logic [AW-1:0] acnt;
    logic          nxt_auto;
    logic [4:0]    nxt_inc;

    assign nxt_inc   = nxt_step + 5'd1;
    assign auto_step = auto_on && tick && (acnt == AW'(AUTO_TICKS - 1));

    // Autoplay enable: toggle in SHOW, drop on prev, exit or last move.
    always_comb begin
        nxt_auto = auto_on;
        if (state == SHOW && prs[BTN_AUTO])
            nxt_auto = !auto_on;
        if (prs[BTN_PREV] || prs[BTN_RST])
            nxt_auto = 1'b0;
        if (nxt != SHOW || nxt_inc >= nxt_cnt)
            nxt_auto = 1'b0;
    end

    // Autoplay tick counter runs only while enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            auto_on <= 1'b0;
            acnt    <= '0;
        end else begin
            auto_on <= nxt_auto;
            if (!nxt_auto || auto_step) acnt <= '0;
            else if (tick)              acnt <= acnt + 1'b1;
        end
    end
`else
    logic unused_auto;

    assign auto_step   = 1'b0;
    assign auto_on     = 1'b0;
    assign unused_auto = ^{prs[BTN_AUTO], AUTO_TICKS[0]};
`endif

endmodule

// File: tb/tb_solve_play_ctrl.sv
// tb_solve_play_ctrl: directed checks of debounce, handshake, timeout
// and stepping, with hand-computed expectations.
module tb_solve_play_ctrl;
    import solve_play_pkg::*;

    localparam int TW = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  btn;
    logic        slv_start;
    logic        slv_done;
    logic        slv_ok;
    logic [4:0]  slv_cnt;
    logic [17:0] slv_ord;
    logic        comp;
    logic [4:0]  step;
    logic [1:0]  move;
    logic [1:0]  st;
    logic        auto_on;

    int n_run  = 0;
    int n_fail = 0;
    int starts = 0;
    logic [TW-1:0] bp;
    int mt;
    bit seen;

    always #5 clk = ~clk;

    solve_play_ctrl #(
        .TICK_W        (TW),
        .MAX_MOVES     (9),
        .TIMEOUT_TICKS (4),
        .AUTO_TICKS    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .slv_start (slv_start),
        .slv_done  (slv_done),
        .slv_ok    (slv_ok),
        .slv_cnt   (slv_cnt),
        .slv_ord   (slv_ord),
        .comp      (comp),
        .step      (step),
        .move      (move),
        .st        (st),
        .auto_on   (auto_on)
    );

    // Count solver start pulses.
    always @(posedge clk) if (slv_start) starts++;

    // Tick model and ticks elapsed while in SOLVE.
    always @(posedge clk) begin
        if (!rst_n) bp <= '0;
        else        bp <= bp + 1'b1;
        if (st != 2'd1)          mt <= 0;
        else if (bp == '1)       mt <= mt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [4:0] m, input int pre);
        btn = '0;
        cyc(pre);
        btn = m;
        cyc(12);
        btn = '0;
        cyc(2);
    endtask

    task automatic done(input logic ok, input logic [4:0] c,
                        input logic [17:0] o);
        slv_done = 1'b1;
        slv_ok   = ok;
        slv_cnt  = c;
        slv_ord  = o;
        cyc(1);
        slv_done = 1'b0;
        slv_ok   = 1'b0;
    endtask

    task automatic wait_mt4();
        for (int i = 0; i < 100 && mt != 4; i++) cyc(1);
        chk("to_ticks", mt, 4);
    endtask

    int nx_step[5] = '{1, 2, 3, 3, 3};
    logic [1:0] nx_mv[5] = '{MV_DOWN, MV_LEFT, MV_RIGHT, MV_RIGHT, MV_RIGHT};
    int pv_step[4] = '{2, 1, 0, 0};
    logic [1:0] pv_mv[4] = '{MV_LEFT, MV_DOWN, MV_UP, MV_UP};

    initial begin
        rst_n    = 1'b0;
        btn      = '0;
        slv_done = 1'b0;
        slv_ok   = 1'b0;
        slv_cnt  = '0;
        slv_ord  = '0;
        cyc(3);
        chk("rst_st", st, 0);
        chk("rst_comp", comp, 0);
        chk("rst_step", step, 0);
        chk("rst_move", move, 0);
        chk("rst_start", slv_start, 0);
        chk("rst_auto", auto_on, 0);
        rst_n = 1'b1;
        cyc(1);

        press(5'(1 << BTN_START), 12);
        chk("start_pulses", starts, 1);
        chk("start_st", st, 1);
        done(1'b1, 5'd4, 18'h000E4);
        chk("done_comp", comp, 1);
        chk("done_st", st, 2);
        chk("done_step", step, 0);
        chk("done_move", move, MV_UP);

        for (int i = 0; i < 5; i++) begin
            press(5'(1 << BTN_NEXT), 12);
            chk("next_step", step, nx_step[i]);
            chk("next_move", move, nx_mv[i]);
        end
        for (int i = 0; i < 4; i++) begin
            press(5'(1 << BTN_PREV), 12);
            chk("prev_step", step, pv_step[i]);
            chk("prev_move", move, pv_mv[i]);
        end

        btn = '0;
        cyc(12);
        btn[BTN_NEXT] = 1'b1;
        cyc(4);
        btn = '0;
        cyc(12);
        chk("glitch_step", step, 0);

        press(5'((1 << BTN_NEXT) | (1 << BTN_PREV)), 12);
        chk("both_step", step, 1);
        chk("both_move", move, MV_DOWN);

`ifndef AUTOPLAY_EN
        press(5'(1 << BTN_AUTO), 12);
        chk("noauto_on", auto_on, 0);
        chk("noauto_step", step, 1);
`endif

        press(5'(1 << BTN_RST), 12);
        chk("rst_btn_st", st, 0);
        chk("rst_btn_comp", comp, 0);
        chk("rst_btn_step", step, 0);
        chk("rst_btn_move", move, 0);

        press(5'(1 << BTN_START), 12);
        chk("to_starts", starts, 2);
        chk("to_st_solve", st, 1);
        wait_mt4();
        chk("to_pre_st", st, 1);
        cyc(1);
        chk("to_fail_st", st, 3);
        chk("to_fail_comp", comp, 0);

        press(5'(1 << BTN_START), 12);
        chk("fail_starts", starts, 3);
        chk("fail_st_solve", st, 1);
        wait_mt4();
        done(1'b1, 5'd2, 18'h0000B);
        chk("race_st", st, 2);
        chk("race_comp", comp, 1);
        chk("race_move", move, MV_RIGHT);

        press(5'(1 << BTN_RST), 12);
        press(5'(1 << BTN_START), 12);
        chk("clamp_starts", starts, 4);
        done(1'b1, 5'd12, 18'h20000);
        for (int i = 0; i < 8; i++) press(5'(1 << BTN_NEXT), 12);
        chk("clamp_step8", step, 8);
        press(5'(1 << BTN_NEXT), 12);
        chk("clamp_sat", step, 8);
        chk("clamp_move", move, MV_LEFT);

        press(5'(1 << BTN_RST), 12);
        btn  = '0;
        cyc(12);
        seen = 1'b0;
        btn  = 5'(1 << BTN_START);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (st == 2'd1) seen = 1'b1;
        end
        btn = 5'((1 << BTN_START) | (1 << BTN_RST));
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (st == 2'd1) seen = 1'b1;
        end
        btn = '0;
        cyc(2);
        chk("mid_saw_solve", seen, 1);
        chk("mid_st", st, 0);
        chk("mid_starts", starts, 5);
        done(1'b1, 5'd3, 18'h00024);
        chk("late_st", st, 0);
        chk("late_comp", comp, 0);

        press(5'(1 << BTN_START), 12);
        chk("rstn_starts", starts, 6);
        rst_n = 1'b0;
        cyc(2);
        chk("rstn_st", st, 0);
        chk("rstn_start", slv_start, 0);
        rst_n = 1'b1;
        cyc(1);
        done(1'b1, 5'd3, 18'h00024);
        chk("rstn_late_st", st, 0);
        chk("rstn_starts2", starts, 6);

`ifdef AUTOPLAY_EN
        press(5'(1 << BTN_START), 12);
        done(1'b1, 5'd3, 18'h00024);
        chk("ap_st", st, 2);
        press(5'(1 << BTN_AUTO), 12);
        chk("ap_on", auto_on, 1);
        for (int i = 0; i < 80 && step != 5'd2; i++) cyc(1);
        chk("ap_step", step, 2);
        cyc(1);
        chk("ap_off", auto_on, 0);
        chk("ap_move", move, MV_LEFT);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
